bdm_target_startup_monitor: RTL and testbench

Target-side counterpart of the host BDM power-up entry sequence. Watches the target supply enable and the single-wire BKGD line. Decides whether the target came up in active background mode or normal run mode, and flags sequences that violate the setup or hold timing. Used as a loopback self-check on the board and as a target model in system benches. Clock is 50 MHz (1 cycle = 20 ns).

---
 rtl/bdm_pkg.sv | 18 +
 rtl/bdm_sync2.sv | 25 ++
 rtl/bdm_target_startup_monitor.sv | 175 +++++++++++++++++
 tb/tb_bdm_target_startup_monitor.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/bdm_pkg.sv
// Shared BDM power-up constants and the target startup monitor state encoding.
// These constants are also used by the host-side startup controller.
package bdm_pkg;

   localparam int unsigned CLK_HZ          = 50_000_000;
   localparam int unsigned BDM_SETUP_CYC   = 150;
   localparam int unsigned BDM_HOLD_CYC    = 600;
   localparam int unsigned BDM_RELEASE_CYC = 500;

   typedef enum logic [2:0] {
      ST_OFF   = 3'd0,
      ST_HOLD  = 3'd1,
      ST_BDM   = 3'd2,
      ST_RUN   = 3'd3,
      ST_FAULT = 3'd4
   } bdm_state_e;

endpackage

// File: rtl/bdm_sync2.sv
// Two-flop synchronizer for a single asynchronous level.
// Ports: clk, rst (sync, active-high), d (async in), q (synchronized out).
// RST_VAL sets the value both flops take on reset.
module bdm_sync2 #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= RST_VAL;
         q    <= RST_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/bdm_target_startup_monitor.sv
// Target-side BDM power-up monitor: classifies a power-up as active background
// mode (BKGD held low across the power rise) or normal run mode, and flags
// setup/hold timing violations of the BKGD low window.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   pwr_in          raw target supply enable (async)
//   bkgd_in         raw BKGD level, 1 = released (async)
//   bdm_active      target in active background mode
//   run_mode        target in normal run mode
//   seq_done        one-cycle pulse on entry to BDM or RUN
//   err_setup       sticky: BKGD low too briefly before power rise
//   err_hold        sticky: BKGD released too early after power rise
//   state_o         current state encoding (debug)
// Optional build macro BDM_STARTUP_MEAS_EN adds meas_setup / meas_hold, the
// measured low-before-power and hold durations in cycles.
module bdm_target_startup_monitor
   import bdm_pkg::*;
#(
   parameter int unsigned SETUP_MIN = BDM_SETUP_CYC,
   parameter int unsigned HOLD_MIN  = BDM_HOLD_CYC,
   parameter int unsigned CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             pwr_in,
   input  logic             bkgd_in,
   output logic             bdm_active,
   output logic             run_mode,
   output logic             seq_done,
   output logic             err_setup,
   output logic             err_hold,
   output logic [2:0]       state_o
`ifdef BDM_STARTUP_MEAS_EN
   ,
   output logic [CNT_W-1:0] meas_setup,
   output logic [CNT_W-1:0] meas_hold
`endif
);

   localparam logic [CNT_W-1:0] SETUP_TH = CNT_W'(SETUP_MIN);
   localparam logic [CNT_W-1:0] HOLD_TH  = CNT_W'(HOLD_MIN);
`ifdef BDM_STARTUP_MEAS_EN
   localparam logic [CNT_W-1:0] LOW_SAT  = '1;
   localparam logic [CNT_W-1:0] HOLD_SAT = '1;
`else
   localparam logic [CNT_W-1:0] LOW_SAT  = SETUP_TH;
   localparam logic [CNT_W-1:0] HOLD_SAT = HOLD_TH;
`endif

   logic             pwr_s, bkgd_s, pwr_prev;
   logic             pwr_rise, pwr_fall;
   bdm_state_e       state_q, state_d;
   logic [CNT_W-1:0] low_cnt, low_cnt_d;
   logic [CNT_W-1:0] hold_cnt, hold_cnt_d;
   logic             bdm_d, run_d, done_d, err_setup_d, err_hold_d;
`ifdef BDM_STARTUP_MEAS_EN
   logic [CNT_W-1:0] meas_setup_d, meas_hold_d;
`endif

   bdm_sync2 #(.RST_VAL(1'b0)) u_sync_pwr  (.clk(clk), .rst(rst), .d(pwr_in),  .q(pwr_s));
   bdm_sync2 #(.RST_VAL(1'b1)) u_sync_bkgd (.clk(clk), .rst(rst), .d(bkgd_in), .q(bkgd_s));

   assign pwr_rise = pwr_s & ~pwr_prev;
   assign pwr_fall = ~pwr_s & pwr_prev;
   assign state_o  = state_q;

   // State, counters and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         pwr_prev   <= 1'b0;
         state_q    <= ST_OFF;
         low_cnt    <= '0;
         hold_cnt   <= '0;
         bdm_active <= 1'b0;
         run_mode   <= 1'b0;
         seq_done   <= 1'b0;
         err_setup  <= 1'b0;
         err_hold   <= 1'b0;
`ifdef BDM_STARTUP_MEAS_EN
         meas_setup <= '0;
         meas_hold  <= '0;
`endif
      end else begin
         pwr_prev   <= pwr_s;
         state_q    <= state_d;
         low_cnt    <= low_cnt_d;
         hold_cnt   <= hold_cnt_d;
         bdm_active <= bdm_d;
         run_mode   <= run_d;
         seq_done   <= done_d;
         err_setup  <= err_setup_d;
         err_hold   <= err_hold_d;
`ifdef BDM_STARTUP_MEAS_EN
         meas_setup <= meas_setup_d;
         meas_hold  <= meas_hold_d;
`endif
      end
   end

   // Next-state and output decode
   always_comb begin
      state_d     = state_q;
      low_cnt_d   = low_cnt;
      hold_cnt_d  = hold_cnt;
      bdm_d       = bdm_active;
      run_d       = run_mode;
      done_d      = 1'b0;
      err_setup_d = err_setup;
      err_hold_d  = err_hold;
`ifdef BDM_STARTUP_MEAS_EN
      meas_setup_d = meas_setup;
      meas_hold_d  = meas_hold;
`endif

      if (pwr_fall) begin
         // Power loss overrides any BKGD event sampled in the same cycle
         state_d    = ST_OFF;
         low_cnt_d  = '0;
         hold_cnt_d = '0;
         bdm_d      = 1'b0;
         run_d      = 1'b0;
      end else begin
         case (state_q)
            ST_OFF: begin
               if (pwr_rise) begin
                  err_setup_d = 1'b0;
                  err_hold_d  = 1'b0;
                  low_cnt_d   = '0;
`ifdef BDM_STARTUP_MEAS_EN
                  meas_setup_d = low_cnt;
`endif
                  if (bkgd_s) begin
                     state_d = ST_RUN;
                     run_d   = 1'b1;
                     done_d  = 1'b1;
                  end else if (low_cnt >= SETUP_TH) begin
                     // The rise cycle already has BKGD low with power up,
                     // so it is the first cycle of hold.
                     state_d    = ST_HOLD;
                     hold_cnt_d = CNT_W'(1);
                  end else begin
                     state_d     = ST_FAULT;
                     err_setup_d = 1'b1;
                  end
               end else if (bkgd_s) begin
                  low_cnt_d = '0;
               end else if (low_cnt != LOW_SAT) begin
                  low_cnt_d = low_cnt + CNT_W'(1);
               end
            end

            ST_HOLD: begin
               if (bkgd_s) begin
`ifdef BDM_STARTUP_MEAS_EN
                  meas_hold_d = hold_cnt;
`endif
                  if (hold_cnt >= HOLD_TH) begin
                     state_d = ST_BDM;
                     bdm_d   = 1'b1;
                     done_d  = 1'b1;
                  end else begin
                     state_d    = ST_FAULT;
                     err_hold_d = 1'b1;
                  end
               end else if (hold_cnt != HOLD_SAT) begin
                  hold_cnt_d = hold_cnt + CNT_W'(1);
               end
            end

            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_bdm_target_startup_monitor.sv
// Self-checking bench for bdm_target_startup_monitor: directed corner cases
// plus randomized power-up sequences predicted from the timing rules.
module tb_bdm_target_startup_monitor;

   localparam int SETUP_MIN = 150;
   localparam int HOLD_MIN  = 600;
   localparam int CNT_W     = 16;
   localparam int S_OFF = 0, S_HOLD = 1, S_BDM = 2, S_RUN = 3, S_FAULT = 4;

   logic clk = 1'b0;
   logic rst, pwr_in, bkgd_in;
   logic bdm_active, run_mode, seq_done, err_setup, err_hold;
   logic [2:0] state_o;
`ifdef BDM_STARTUP_MEAS_EN
   logic [CNT_W-1:0] meas_setup, meas_hold;
`endif

   int tests = 0;
   int fails = 0;
   // Model of the sticky/held results between power-ups
   int m_st = S_OFF;
   bit m_es = 1'b0;
   bit m_eh = 1'b0;

   always #10 clk = ~clk;

   bdm_target_startup_monitor #(.SETUP_MIN(SETUP_MIN), .HOLD_MIN(HOLD_MIN), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .pwr_in(pwr_in), .bkgd_in(bkgd_in),
      .bdm_active(bdm_active), .run_mode(run_mode), .seq_done(seq_done),
      .err_setup(err_setup), .err_hold(err_hold), .state_o(state_o)
`ifdef BDM_STARTUP_MEAS_EN
      , .meas_setup(meas_setup), .meas_hold(meas_hold)
`endif
   );

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_outputs(input string tag, input int st, input bit bdm, input bit run,
                              input bit done, input bit es, input bit eh);
      chk({tag, "/state"}, 32'(state_o), st);
      chk({tag, "/bdm_active"}, 32'(bdm_active), 32'(bdm));
      chk({tag, "/run_mode"}, 32'(run_mode), 32'(run));
      chk({tag, "/seq_done"}, 32'(seq_done), 32'(done));
      chk({tag, "/err_setup"}, 32'(err_setup), 32'(es));
      chk({tag, "/err_hold"}, 32'(err_hold), 32'(eh));
   endtask

   // One power-up from OFF. low=0: BKGD stays released. Otherwise BKGD goes low
   // s cycles before power rises and is released h cycles after it.
   task automatic power_up(input string tag, input bit low, input int s, input int h);
      int exp_st;
      bit via_hold;
      via_hold = low && (s >= SETUP_MIN);
      if (!low)               exp_st = S_RUN;
      else if (!via_hold)     exp_st = S_FAULT;
      else if (h < HOLD_MIN)  exp_st = S_FAULT;
      else                    exp_st = S_BDM;
      m_es = low && !via_hold;
      m_eh = via_hold && (h < HOLD_MIN);

      if (low) begin
         bkgd_in = 1'b0;
         tick(s);
      end
      pwr_in = 1'b1;
      if (via_hold) begin
         tick(3);
         chk_outputs({tag, "/in_hold"}, S_HOLD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
         tick(h - 3);
         bkgd_in = 1'b1;
      end
      tick(2);
      chk({tag, "/pre_state"}, 32'(state_o), via_hold ? S_HOLD : S_OFF);
      chk({tag, "/pre_done"}, 32'(seq_done), 0);
      tick(1);
      chk_outputs({tag, "/result"}, exp_st, exp_st == S_BDM, exp_st == S_RUN,
                  exp_st == S_BDM || exp_st == S_RUN, m_es, m_eh);
      tick(1);
      chk({tag, "/done_drop"}, 32'(seq_done), 0);
`ifdef BDM_STARTUP_MEAS_EN
      if (exp_st == S_BDM) begin
         chk({tag, "/meas_setup_near"}, 32'(int'(meas_setup) - s + 2 <= 4 && int'(meas_setup) - s + 2 >= 0), 1);
         chk({tag, "/meas_hold_near"}, 32'(int'(meas_hold) - h + 2 <= 4 && int'(meas_hold) - h + 2 >= 0), 1);
      end
`endif
      m_st = exp_st;
   endtask

   task automatic power_down(input string tag);
      pwr_in  = 1'b0;
      bkgd_in = 1'b1;
      tick(2);
      chk({tag, "/pre_state"}, 32'(state_o), m_st);
      tick(1);
      chk_outputs({tag, "/off"}, S_OFF, 1'b0, 1'b0, 1'b0, m_es, m_eh);
      m_st = S_OFF;
      tick(4);
   endtask

   initial begin
      #10_000_000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1; pwr_in = 1'b0; bkgd_in = 1'b1;
      tick(3);
      chk_outputs("reset", S_OFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      tick(4);

      // Normal BDM entry, then BKGD activity in BDM is ignored
      power_up("bdm_normal", 1'b1, 200, 700);
      for (int i = 0; i < 3; i++) begin
         bkgd_in = 1'b0; tick(7);
         bkgd_in = 1'b1; tick(7);
         chk_outputs("bdm_toggle", S_BDM, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      end
      power_down("bdm_drop");

      // Normal run
      power_up("run_normal", 1'b0, 0, 0);
      power_down("run_drop");

      // Setup violation, sticky across power-down, cleared by a clean entry
      power_up("setup_short", 1'b1, 100, 0);
      power_down("setup_drop");
      power_up("clean_after_setup", 1'b1, 200, 700);
      power_down("clean_drop");

      // Boundaries
      power_up("setup_149", 1'b1, 149, 0);
      power_down("setup_149_drop");
      power_up("hold_599", 1'b1, 200, 599);
      power_down("hold_599_drop");
      power_up("exact_150_600", 1'b1, 150, 600);
      power_down("exact_drop");

      // Power rise and BKGD release in the same cycle: released level wins
      bkgd_in = 1'b0;
      tick(200);
      bkgd_in = 1'b1; pwr_in = 1'b1;
      tick(3);
      chk_outputs("rise_and_release", S_RUN, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      m_st = S_RUN; m_es = 1'b0; m_eh = 1'b0;
      power_down("rise_and_release_drop");

      // Power fall and BKGD release together in HOLD: power fall wins, no error
      bkgd_in = 1'b0;
      tick(200);
      pwr_in = 1'b1;
      tick(300);
      pwr_in = 1'b0; bkgd_in = 1'b1;
      tick(3);
      chk_outputs("fall_and_release", S_OFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick(4);

      // Reset mid-HOLD
      bkgd_in = 1'b0;
      tick(200);
      pwr_in = 1'b1;
      tick(302);
      chk({"mid_rst/in_hold"}, 32'(state_o), S_HOLD);
      rst = 1'b1; pwr_in = 1'b0; bkgd_in = 1'b1;
      tick(1);
      chk_outputs("mid_rst", S_OFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef BDM_STARTUP_MEAS_EN
      chk("mid_rst/meas_setup", 32'(meas_setup), 0);
      chk("mid_rst/meas_hold", 32'(meas_hold), 0);
`endif
      rst = 1'b0;
      tick(4);

      // Reset clears a sticky setup error
      power_up("setup_before_rst", 1'b1, 60, 0);
      rst = 1'b1; pwr_in = 1'b0; bkgd_in = 1'b1;
      tick(1);
      chk_outputs("rst_clears_err", S_OFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      rst = 1'b0; m_st = S_OFF; m_es = 1'b0; m_eh = 1'b0;
      tick(4);

      // Randomized power-ups around the thresholds
      for (int i = 0; i < 10; i++) begin
         bit low;
         int s, h;
         low = ($urandom_range(0, 3) != 0);
         s   = int'($urandom_range(130, 175));
         h   = int'($urandom_range(570, 640));
         power_up("random", low, s, h);
         power_down("random_drop");
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
